// File: rtl/cla_adder_32.sv
// ---------------------------------------------------------------------------
// cla_adder_32
//
// Purpose:
//   Registered carry-lookahead adder. It computes {Cout, S} = A + B + Cin as
//   an exact (WIDTH+1)-bit sum. This is the arithmetic core of the ALU AddSub
//   section. The combinational core has two lookahead levels:
//     1. Bit level: g/p for every bit, folded into 4-bit group G/P.
//     2. Group level: lookahead over all group G/P that produces the carry
//        into every group (c4, c8, ...) and the final carry (c[WIDTH]).
//   The carries inside each group come from a 4-bit lookahead that is seeded
//   with that group's carry-in. The result register adds one cycle of latency
//   and raises a valid flag.
//
// Optional feature:
//   CLA_ADDER_SUB_EN - when this macro is defined, the block gains a Sub input.
//   The effective B becomes B ^ {WIDTH{Sub}} and the effective carry-in
//   becomes Cin ^ Sub, which gives A - B (Cin=0) or A - B - 1 (Cin=1).
//   In that mode Cout=1 means "no borrow". When the macro is undefined, the
//   block only adds.
//
// Parameters:
//   WIDTH      operand width, must be a multiple of 4 (default 32)
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      A/B/Cin (and Sub) are valid this cycle
//   A          in   WIDTH  operand A, unsigned
//   B          in   WIDTH  operand B, unsigned
//   Cin        in   1      carry-in
//   Sub        in   1      subtract select (only with CLA_ADDER_SUB_EN)
//   S          out  WIDTH  registered sum
//   Cout       out  1      registered carry-out
//   out_valid  out  1      S/Cout hold a new result this cycle
// ---------------------------------------------------------------------------
module cla_adder_32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
`ifdef CLA_ADDER_SUB_EN
    input  logic             Sub,
`endif
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             out_valid
);

    localparam int NG = WIDTH / 4;

    logic [WIDTH-1:0] bEff;
    logic             cinEff;
    logic [WIDTH-1:0] bitG;
    logic [WIDTH-1:0] bitP;
    logic [NG-1:0]    grpG;
    logic [NG-1:0]    grpP;
    logic [NG:0]      grpC;
    logic [WIDTH-1:0] bitC;
    logic [WIDTH-1:0] sumD;
    logic             coutD;

    logic [WIDTH-1:0] sumQ;
    logic             coutQ;
    logic             validQ;

`ifdef CLA_ADDER_SUB_EN
    // Subtraction is addition of the ones' complement with the carry-in flipped.
    assign bEff   = B ^ {WIDTH{Sub}};
    assign cinEff = Cin ^ Sub;
`else
    assign bEff   = B;
    assign cinEff = Cin;
`endif

    assign bitG = A & bEff;
    assign bitP = A ^ bEff;

    // First lookahead level: collapse each 4-bit slice into a group G/P.
    always_comb begin : groupGenProp
        grpG = '0;
        grpP = '0;
        for (int k = 0; k < NG; k++) begin
            grpP[k] = bitP[4*k+3] & bitP[4*k+2] & bitP[4*k+1] & bitP[4*k];
            grpG[k] = bitG[4*k+3]
                    | (bitP[4*k+3] & bitG[4*k+2])
                    | (bitP[4*k+3] & bitP[4*k+2] & bitG[4*k+1])
                    | (bitP[4*k+3] & bitP[4*k+2] & bitP[4*k+1] & bitG[4*k]);
        end
    end

    // Second lookahead level. Each group carry is a flat sum of products over
    // the lower groups' G/P and Cin, so no group waits on its neighbour's
    // carry. grpC[NG] is the carry out of the whole word.
    always_comb begin : groupCarries
        logic term;
        grpC = '0;
        term = 1'b0;
        for (int k = 0; k <= NG; k++) begin
            term = cinEff;
            for (int m = 0; m < k; m++) begin
                term = term & grpP[m];
            end
            grpC[k] = term;
            for (int j = 0; j < k; j++) begin
                term = grpG[j];
                for (int m = j + 1; m < k; m++) begin
                    term = term & grpP[m];
                end
                grpC[k] = grpC[k] | term;
            end
        end
    end

    // Carries inside each group: a 4-bit lookahead seeded with the group
    // carry-in, so this adds only one product/sum stage after grpC settles.
    always_comb begin : bitCarries
        logic term;
        bitC = '0;
        term = 1'b0;
        for (int k = 0; k < NG; k++) begin
            for (int i = 0; i < 4; i++) begin
                term = grpC[k];
                for (int m = 0; m < i; m++) begin
                    term = term & bitP[4*k+m];
                end
                bitC[4*k+i] = term;
                for (int j = 0; j < i; j++) begin
                    term = bitG[4*k+j];
                    for (int m = j + 1; m < i; m++) begin
                        term = term & bitP[4*k+m];
                    end
                    bitC[4*k+i] = bitC[4*k+i] | term;
                end
            end
        end
    end

    assign sumD  = bitP ^ bitC;
    assign coutD = grpC[NG];

    // Result register. It only captures on valid operands; otherwise the last
    // result stays visible and only the valid flag drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sumQ   <= '0;
            coutQ  <= 1'b0;
            validQ <= 1'b0;
        end else begin
            validQ <= in_valid;
            if (in_valid) begin
                sumQ  <= sumD;
                coutQ <= coutD;
            end
        end
    end

    assign S         = sumQ;
    assign Cout      = coutQ;
    assign out_valid = validQ;

endmodule

// File: tb/tb_cla_adder_32.sv
// ---------------------------------------------------------------------------
// tb_cla_adder_32
//
// Bench for cla_adder_32. A reference model built from plain 33-bit
// arithmetic tracks the registered outputs. A compare process checks the DUT
// against that model on every falling clock edge. Directed vectors carry
// hand-computed literal expectations, which also pin the model itself.
// ---------------------------------------------------------------------------
module tb_cla_adder_32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        inValid = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic [31:0] s;
    logic        cout;
    logic        outValid;

    logic [31:0] modelS = '0;
    logic        modelCout = 1'b0;
    logic        modelValid = 1'b0;
    logic        compareEn = 1'b0;

    int checks = 0;
    int errors = 0;

    cla_adder_32 #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (inValid),
        .A         (a),
        .B         (b),
        .Cin       (cin),
`ifdef CLA_ADDER_SUB_EN
        .Sub       (sub),
`endif
        .S         (s),
        .Cout      (cout),
        .out_valid (outValid)
    );

    always #5 clk = ~clk;

    // Reference result: an exact 33-bit sum, with subtraction expressed as an
    // inverted B plus a flipped carry-in.
    function automatic logic [32:0] refSum(input logic [31:0] x, input logic [31:0] y,
                                           input logic ci, input logic sb);
        logic [32:0] yy;
        yy = {1'b0, (sb ? ~y : y)};
        return {1'b0, x} + yy + {32'd0, (ci ^ sb)};
    endfunction

    // Model of the registered result, including the asynchronous reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            modelS     <= '0;
            modelCout  <= 1'b0;
            modelValid <= 1'b0;
        end else begin
            modelValid <= inValid;
            if (inValid) begin
                {modelCout, modelS} <= refSum(a, b, cin, sub);
            end
        end
    end

    // Compare the outputs against the model every cycle, away from the active edge.
    always @(negedge clk) begin
        if (compareEn) begin
            checks++;
            if (outValid !== modelValid) begin
                errors++;
                $display("[TB] FAIL model_valid t=%0t got %b want %b", $time, outValid, modelValid);
            end
            checks++;
            if ({cout, s} !== {modelCout, modelS}) begin
                errors++;
                $display("[TB] FAIL model_result t=%0t got %b/%h want %b/%h",
                         $time, cout, s, modelCout, modelS);
            end
        end
    end

    // Drive one cycle of operands and wait until the registered result is visible.
    task automatic applyStimulus(input logic [31:0] aIn, input logic [31:0] bIn,
                                 input logic cinIn, input logic subIn, input logic vIn);
        a       = aIn;
        b       = bIn;
        cin     = cinIn;
        sub     = subIn;
        inValid = vIn;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] expS,
                               input logic expCout, input logic expValid);
        checks++;
        if ({outValid, cout, s} !== {expValid, expCout, expS}) begin
            errors++;
            $display("[TB] FAIL %s got valid=%b cout=%b s=%h want valid=%b cout=%b s=%h",
                     name, outValid, cout, s, expValid, expCout, expS);
        end
    endtask

    initial begin
        // Reset held while valid operands are presented; they must be discarded.
        a = 32'hFFFF_FFFF; b = 32'h0000_0001; cin = 1'b0; sub = 1'b0; inValid = 1'b1;
        #2 rst_n = 1'b0;
        compareEn = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("reset_hold", 32'h0, 1'b0, 1'b0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_release", 32'h0000_0000, 1'b1, 1'b1);

        // Full carry chain through every group, then the same operands without Cin.
        applyStimulus(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        checkOutput("full_carry", 32'h0000_0000, 1'b1, 1'b1);
        applyStimulus(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
        checkOutput("no_carry_ones", 32'hFFFF_FFFF, 1'b0, 1'b1);

        // Group boundaries and the top bit.
        applyStimulus(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
        checkOutput("group_boundary", 32'h0001_0000, 1'b0, 1'b1);
        applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 1'b1);
        checkOutput("msb_carry", 32'h0000_0001, 1'b1, 1'b1);
        applyStimulus(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
        checkOutput("zero_zero", 32'h0000_0000, 1'b0, 1'b1);

        // Back-to-back operations, then a hold with in_valid low.
        applyStimulus(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 1'b1);
        checkOutput("b2b_1", 32'h0000_0003, 1'b0, 1'b1);
        applyStimulus(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, 1'b1);
        checkOutput("b2b_2", 32'hACF1_3569, 1'b0, 1'b1);
        applyStimulus(32'hFFFF_FFFE, 32'h0000_0001, 1'b1, 1'b0, 1'b1);
        checkOutput("b2b_3", 32'h0000_0000, 1'b1, 1'b1);
        applyStimulus(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, 1'b0);
        checkOutput("hold_1", 32'h0000_0000, 1'b1, 1'b0);
        applyStimulus(32'h0000_0005, 32'h0000_0006, 1'b1, 1'b0, 1'b0);
        checkOutput("hold_2", 32'h0000_0000, 1'b1, 1'b0);

        // Reset asserted mid-stream, between clock edges.
        applyStimulus(32'h0000_0005, 32'h0000_0006, 1'b0, 1'b0, 1'b1);
        checkOutput("pre_midreset", 32'h0000_000B, 1'b0, 1'b1);
        a = 32'h7FFF_FFFF; b = 32'h0000_0001;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 checkOutput("midreset_async", 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("midreset_hold", 32'h0, 1'b0, 1'b0);
        rst_n = 1'b1;
        applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
        checkOutput("post_midreset", 32'h8000_0000, 1'b0, 1'b1);

`ifdef CLA_ADDER_SUB_EN
        applyStimulus(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 1'b1);
        checkOutput("sub_borrow", 32'hFFFF_FFFE, 1'b0, 1'b1);
        applyStimulus(32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 1'b1);
        checkOutput("sub_no_borrow", 32'h0000_0002, 1'b1, 1'b1);
        applyStimulus(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 1'b1);
        checkOutput("sub_borrow_in", 32'h0000_0001, 1'b1, 1'b1);
`endif

        // Random operands, mostly back-to-back with occasional idle cycles;
        // the model and the compare process cover these.
        for (int i = 0; i < 10000; i++) begin
            a       = $urandom;
            b       = $urandom;
            cin     = 1'($urandom_range(0, 1));
`ifdef CLA_ADDER_SUB_EN
            sub     = 1'($urandom_range(0, 1));
`else
            sub     = 1'b0;
`endif
            inValid = ($urandom_range(0, 7) != 0);
            @(negedge clk);
        end
        inValid = 1'b0;
        @(negedge clk);
        compareEn = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
